// File: rtl/eeg_wram_fetch.sv
// eeg_wram_fetch: WRAM-lane read initiator. Issues strided addresses under FIFO credit and
// presents the returned words to the engine. Optional protocol checker: EEG_WRAM_FETCH_CHK_EN.
module eeg_wram_fetch #(
    parameter int ADD_AW     = 13,
    parameter int DAT_DW     = 8,
    parameter int LEN_DW     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              IS_IDLE,
    input  logic              CFG_VLD,
    output logic              CFG_RDY,
    input  logic [ADD_AW-1:0] CFG_BASE,
    input  logic [ADD_AW-1:0] CFG_STEP,
    input  logic [LEN_DW-1:0] CFG_LEN,
    output logic              ETOW_ADD_VLD,
    output logic              ETOW_ADD_LST,
    input  logic              ETOW_ADD_RDY,
    output logic [ADD_AW-1:0] ETOW_ADD_ADD,
    input  logic              WTOE_DAT_VLD,
    input  logic              WTOE_DAT_LST,
    output logic              WTOE_DAT_RDY,
    input  logic [DAT_DW-1:0] WTOE_DAT_DAT,
    output logic              OUT_DAT_VLD,
    output logic              OUT_DAT_LST,
    input  logic              OUT_DAT_RDY,
    output logic [DAT_DW-1:0] OUT_DAT_DAT,
    output logic              DONE,
    output logic              ERR
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_DW-1:0] IDX_ONE = LEN_DW'(1);
    localparam logic [LEN_DW:0]   RCV_ONE = (LEN_DW + 1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ISSUE = 3'b010,
        DRAIN = 3'b100
    } state_t;

    state_t state_q, state_d;

    logic [ADD_AW-1:0] step_q, add_q;
    logic [LEN_DW-1:0] len_q, idx_q;
    logic              add_vld_q, add_lst_q, add_vld_d;
    logic [LEN_DW:0]   rcv_cnt_q;
    logic [CNT_W-1:0]  outst_q, outst_d, fill_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DAT_DW-1:0] dat_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] lst_mem;
    logic              done_q;
    logic              cfg_fire, add_fire, push, pop, full, empty, head_lst, rcv_tag;

    assign IS_IDLE  = (state_q == IDLE);
    assign CFG_RDY  = IS_IDLE;
    assign cfg_fire = CFG_VLD && IS_IDLE;
    assign add_fire = add_vld_q && ETOW_ADD_RDY;
    assign full     = (fill_q == DEPTH_C);
    assign empty    = (fill_q == '0);
    assign push     = WTOE_DAT_VLD && !full;
    assign pop      = !empty && OUT_DAT_RDY;
    assign head_lst = lst_mem[rd_ptr_q];
    assign rcv_tag  = (rcv_cnt_q == {1'b0, len_q});
    // Credit: a word occupies a slot from address accept until it leaves on OUT.
    assign outst_d  = outst_q + CNT_W'(add_fire) - CNT_W'(pop);

    // NOTE: state_d gets its default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_fire) state_d = ISSUE;
            ISSUE:   if (add_fire && add_lst_q) state_d = DRAIN;
            DRAIN:   if (pop && head_lst) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Computed from next-cycle credit so a pending address never drops before acceptance.
    assign add_vld_d = (state_d == ISSUE) && (outst_d < DEPTH_C);

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAIN) && pop && head_lst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_vld_q <= 1'b0;
            add_lst_q <= 1'b0;
            add_q     <= '0;
            idx_q     <= '0;
            step_q    <= '0;
            len_q     <= '0;
        end else begin
            add_vld_q <= add_vld_d;
            if (cfg_fire) begin
                add_q     <= CFG_BASE;
                step_q    <= CFG_STEP;
                len_q     <= CFG_LEN;
                idx_q     <= '0;
                add_lst_q <= (CFG_LEN == '0);
            end else if (add_fire && !add_lst_q) begin
                add_q     <= add_q + step_q;
                idx_q     <= idx_q + IDX_ONE;
                add_lst_q <= ((idx_q + IDX_ONE) == len_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcv_cnt_q <= '0;
            outst_q   <= '0;
            fill_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            if (cfg_fire)  rcv_cnt_q <= '0;
            else if (push) rcv_cnt_q <= rcv_cnt_q + RCV_ONE;
            outst_q <= outst_d;
            fill_q  <= fill_q + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: FIFO storage is not reset; the head is gated by empty so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (push) begin
            dat_mem[wr_ptr_q] <= WTOE_DAT_DAT;
            lst_mem[wr_ptr_q] <= rcv_tag;
        end
    end

    assign ETOW_ADD_VLD = add_vld_q;
    assign ETOW_ADD_LST = add_lst_q;
    assign ETOW_ADD_ADD = add_q;
    assign WTOE_DAT_RDY = !full;
    assign OUT_DAT_VLD  = !empty;
    assign OUT_DAT_LST  = !empty && head_lst;
    assign OUT_DAT_DAT  = empty ? '0 : dat_mem[rd_ptr_q];
    assign DONE         = done_q;

`ifdef EEG_WRAM_FETCH_CHK_EN
    logic [LEN_DW:0] acc_cnt_q;
    logic            err_q;

    // A return with nothing unanswered, or a WRAM last flag disagreeing with our count, is a protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (cfg_fire)      acc_cnt_q <= '0;
            else if (add_fire) acc_cnt_q <= acc_cnt_q + RCV_ONE;
            if (cfg_fire)
                err_q <= 1'b0;
            else if (push && ((rcv_cnt_q == acc_cnt_q) || (WTOE_DAT_LST != rcv_tag)))
                err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    logic chk_unused;
    assign chk_unused = WTOE_DAT_LST;
    assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_eeg_wram_fetch.sv
// tb_eeg_wram_fetch: randomized WRAM/engine stimulus against a queue-based reference model.
module tb_eeg_wram_fetch;
    localparam int AW = 13, DW = 8, LW = 13, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          IS_IDLE, CFG_RDY, ETOW_ADD_VLD, ETOW_ADD_LST, WTOE_DAT_RDY;
    logic          OUT_DAT_VLD, OUT_DAT_LST, DONE, ERR;
    logic          CFG_VLD = 1'b0, ETOW_ADD_RDY = 1'b0, WTOE_DAT_VLD = 1'b0;
    logic          WTOE_DAT_LST = 1'b0, OUT_DAT_RDY = 1'b1;
    logic [AW-1:0] CFG_BASE = '0, CFG_STEP = '0, ETOW_ADD_ADD;
    logic [LW-1:0] CFG_LEN = '0;
    logic [DW-1:0] WTOE_DAT_DAT = '0, OUT_DAT_DAT;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic err_exp = 1'b0;
    int   f_rel, span;

    eeg_wram_fetch #(.ADD_AW(AW), .DAT_DW(DW), .LEN_DW(LW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .IS_IDLE(IS_IDLE),
        .CFG_VLD(CFG_VLD), .CFG_RDY(CFG_RDY), .CFG_BASE(CFG_BASE), .CFG_STEP(CFG_STEP), .CFG_LEN(CFG_LEN),
        .ETOW_ADD_VLD(ETOW_ADD_VLD), .ETOW_ADD_LST(ETOW_ADD_LST), .ETOW_ADD_RDY(ETOW_ADD_RDY),
        .ETOW_ADD_ADD(ETOW_ADD_ADD),
        .WTOE_DAT_VLD(WTOE_DAT_VLD), .WTOE_DAT_LST(WTOE_DAT_LST), .WTOE_DAT_RDY(WTOE_DAT_RDY),
        .WTOE_DAT_DAT(WTOE_DAT_DAT),
        .OUT_DAT_VLD(OUT_DAT_VLD), .OUT_DAT_LST(OUT_DAT_LST), .OUT_DAT_RDY(OUT_DAT_RDY),
        .OUT_DAT_DAT(OUT_DAT_DAT), .DONE(DONE), .ERR(ERR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // WRAM content: any fixed function of the address.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        logic [15:0] t;
        t = {3'b000, a} * 16'd29 + 16'd7;
        return t[7:0] ^ t[12:5];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_is_idle"}, IS_IDLE, 1);
        check({tag, "_cfg_rdy"}, CFG_RDY, 1);
        check({tag, "_add_vld"}, ETOW_ADD_VLD, 0);
        check({tag, "_add_lst"}, ETOW_ADD_LST, 0);
        check({tag, "_add_add"}, ETOW_ADD_ADD, 0);
        check({tag, "_wtoe_rdy"}, WTOE_DAT_RDY, 1);
        check({tag, "_out_vld"}, OUT_DAT_VLD, 0);
        check({tag, "_out_lst"}, OUT_DAT_LST, 0);
        check({tag, "_out_dat"}, OUT_DAT_DAT, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_err"}, ERR, 0);
    endtask

    // One command end to end. Called and returns at posedge+1 with the DUT idle,
    // except when abort_at>=0: returns at the negedge once abort_at addresses are about to be accepted.
    task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] step, input int len,
                           input int lat, input int out_pct, input int add_pct, input int hold,
                           input int inject, input int abort_at, output int first_rel, output int span_o);
        logic [AW-1:0] wq[$];
        int            due[$];
        int            k = 0, n = 0, r = 0, acc_cyc, limit;
        logic          exp_done;
        logic [AW-1:0] ea;
        first_rel = -1;
        span_o    = -1;
        check("err_hold", ERR, err_exp);
        check("cfg_rdy_pre", CFG_RDY, 1);
        CFG_VLD  = 1'b1;
        CFG_BASE = base;
        CFG_STEP = step;
        CFG_LEN  = LW'(len);
        @(posedge clk); #1;
        CFG_VLD = 1'b0;
        acc_cyc = cyc;
        limit   = cyc + 3000;
        err_exp = 1'b0;
        forever begin
            ETOW_ADD_RDY = ($urandom_range(99) < add_pct);
            OUT_DAT_RDY  = (cyc < acc_cyc + hold) ? 1'b0 : ($urandom_range(99) < out_pct);
            if (wq.size() > 0 && due[0] <= cyc) begin
                WTOE_DAT_VLD = 1'b1;
                WTOE_DAT_DAT = mem_val(wq[0]);
                WTOE_DAT_LST = (r == len) || (r == inject);
            end else begin
                WTOE_DAT_VLD = 1'b0;
                WTOE_DAT_DAT = '0;
                WTOE_DAT_LST = 1'b0;
            end
            @(negedge clk);
            exp_done = (n == len + 1);
            check("done", DONE, exp_done);
            check("is_idle", IS_IDLE, exp_done);
            check("cfg_rdy", CFG_RDY, exp_done);
            check("err", ERR, err_exp);
            check("add_vld", ETOW_ADD_VLD, (k <= len) && (k - n < DEPTH));
            check("wtoe_rdy", WTOE_DAT_RDY, (r - n) < DEPTH);
            check("out_vld", OUT_DAT_VLD, r > n);
            if (hold > 0 && cyc == acc_cyc + hold)
                check("hold_issued", k, (len + 1 < DEPTH) ? len + 1 : DEPTH);
            if (exp_done) break;
            if (cyc > limit) begin
                check("timeout", exp_done, 1);
                break;
            end
            if (ETOW_ADD_VLD) begin
                ea = base + AW'(k) * step;
                check("add_addr", ETOW_ADD_ADD, ea);
                check("add_lst", ETOW_ADD_LST, k == len);
                if (ETOW_ADD_RDY) begin
                    wq.push_back(ea);
                    due.push_back(cyc + lat);
                    if (k == 0) first_rel = cyc - acc_cyc;
                    span_o = cyc - acc_cyc - first_rel;
                    k++;
                end
            end
            if (WTOE_DAT_VLD && WTOE_DAT_RDY) begin
`ifdef EEG_WRAM_FETCH_CHK_EN
                if (WTOE_DAT_LST !== (r == len)) err_exp = 1'b1;
`endif
                void'(wq.pop_front());
                void'(due.pop_front());
                r++;
            end
            if (OUT_DAT_VLD) begin
                check("out_dat", OUT_DAT_DAT, mem_val(base + AW'(n) * step));
                check("out_lst", OUT_DAT_LST, n == len);
                if (OUT_DAT_RDY) n++;
            end
            if (abort_at >= 0 && k == abort_at) return;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        WTOE_DAT_VLD = 1'b0;
        OUT_DAT_RDY  = 1'b1;
        @(negedge clk);
        check("done_pulse", DONE, 0);
        check("wram_drained", wq.size(), 0);
        check("err_after", ERR, err_exp);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Sequential burst with single-cycle WRAM: eight back-to-back addresses.
        run_cmd(13'h0010, 13'd1, 7, 1, 100, 100, 0, -1, -1, f_rel, span);
        check("t1_first_rel", f_rel, 0);
        check("t1_span", span, 7);

        // Address wrap past the top of the WRAM space.
        run_cmd(13'h1FFE, 13'd1, 3, 2, 100, 100, 0, -1, -1, f_rel, span);
        check("t2_span", span, 3);

        // Engine stalled: issue must stop at FIFO_DEPTH outstanding, then resume.
        run_cmd(13'h0200, 13'd4, 9, 1, 100, 100, 20, -1, -1, f_rel, span);

        // Single-word command.
        run_cmd(13'h0033, 13'd5, 0, 1, 100, 100, 0, -1, -1, f_rel, span);
        check("t4_span", span, 0);

        // WRAM raises last early on word 2; the checker build flags it until the next accept.
        run_cmd(13'h0040, 13'd2, 3, 1, 100, 100, 0, 2, -1, f_rel, span);
        run_cmd(13'h0050, 13'd1, 2, 1, 100, 100, 0, -1, -1, f_rel, span);

        for (int t = 0; t < 20; t++)
            run_cmd(AW'($urandom), AW'($urandom), $urandom_range(0, 20), $urandom_range(1, 6),
                    $urandom_range(30, 100), $urandom_range(30, 100), 0, -1, -1, f_rel, span);

        // Reset in the middle of ISSUE after three addresses.
        run_cmd(13'h0100, 13'd3, 7, 2, 100, 100, 0, -1, 3, f_rel, span);
        @(posedge clk); #2;
        rst_n        = 1'b0;
        ETOW_ADD_RDY = 1'b0;
        WTOE_DAT_VLD = 1'b0;
        OUT_DAT_RDY  = 1'b1;
        err_exp      = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd(13'h0300, 13'd7, 7, 3, 80, 80, 0, -1, -1, f_rel, span);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
